// File: rtl/ac_ph_avg.sv
// Block averager for {amplitude, phase} frame results: plain mean of ac, wrap-safe circular mean of ph.
// Define AC_PH_AVG_ROUND_EN for round-half-up outputs; otherwise results truncate (phase floors).
`timescale 1ns/1ps
module ac_ph_avg #(
    parameter int LOG2_N = 2,
    parameter int PH_PI  = 1073741824
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_vld,
    input  logic [31:0]          ac,
    input  logic signed [31:0]   ph,
    input  logic                 i_clear,
    output logic [31:0]          o_ac,
    output logic signed [31:0]   o_ph,
    output logic                 o_vld,
    output logic [LOG2_N:0]      o_cnt
);

    localparam int CNT_W = LOG2_N + 1;
    localparam int N     = 1 << LOG2_N;
    localparam int AC_W  = 32 + LOG2_N;
    localparam int D_W   = 33 + LOG2_N;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
`ifdef AC_PH_AVG_ROUND_EN
    localparam int RND = N >> 1;
`else
    localparam int RND = 0;
`endif
    localparam logic signed [33:0] PI34     = 34'(PH_PI);
    localparam logic signed [33:0] TWO_PI34 = 34'(2 * longint'(PH_PI));

    function automatic logic signed [33:0] wrap(input logic signed [33:0] x);
        if (x > PI34)
            return x - TWO_PI34;
        else if (x <= -PI34)
            return x + TWO_PI34;
        return x;
    endfunction

    // Stage A: per-sample phase offset from the block's first sample
    logic                    a_vld_reg;
    logic [31:0]             a_ac_reg;
    logic signed [33:0]      a_d_reg;
    logic signed [31:0]      ph_ref_reg;
    logic [CNT_W-1:0]        a_cnt_reg;
    logic [CNT_W-1:0]        a_cnt_cur;
    logic [CNT_W-1:0]        a_cnt_next;
    logic signed [33:0]      ph_ext;
    logic signed [33:0]      ph_w;
    logic signed [33:0]      ref_ext;
    logic signed [33:0]      d_w;

    // Stage A keeps its own count so back-to-back samples see the block start before o_cnt catches up
    assign a_cnt_cur  = i_clear ? '0 : a_cnt_reg;
    assign a_cnt_next = (a_cnt_cur == LAST) ? '0 : a_cnt_cur + 1'b1;
    assign ph_ext     = ph;
    assign ph_w       = wrap(ph_ext);
    assign ref_ext    = ph_ref_reg;
    assign d_w        = wrap(ph_w - ref_ext);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_vld_reg  <= 1'b0;
            a_ac_reg   <= '0;
            a_d_reg    <= '0;
            ph_ref_reg <= '0;
            a_cnt_reg  <= '0;
        end else begin
            a_vld_reg <= i_vld;
            a_cnt_reg <= i_vld ? a_cnt_next : a_cnt_cur;
            if (i_vld) begin
                a_ac_reg <= ac;
                if (a_cnt_cur == '0) begin
                    ph_ref_reg <= 32'(ph_w);
                    a_d_reg    <= '0;
                end else begin
                    a_d_reg <= d_w;
                end
            end
        end
    end

    // Stage B: accumulate, hand the full block to the output stage
    logic [AC_W-1:0]         sum_ac_reg;
    logic [AC_W-1:0]         hold_ac_reg;
    logic [AC_W-1:0]         sum_ac_next;
    logic signed [D_W-1:0]   sum_d_reg;
    logic signed [D_W-1:0]   hold_d_reg;
    logic signed [D_W-1:0]   sum_d_next;
    logic signed [D_W-1:0]   a_d_ext;
    logic signed [31:0]      hold_ref_reg;
    logic                    hold_vld_reg;

    assign a_d_ext     = D_W'(a_d_reg);
    assign sum_ac_next = sum_ac_reg + AC_W'(a_ac_reg);
    assign sum_d_next  = sum_d_reg + a_d_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_ac_reg   <= '0;
            sum_d_reg    <= '0;
            hold_ac_reg  <= '0;
            hold_d_reg   <= '0;
            hold_ref_reg <= '0;
            hold_vld_reg <= 1'b0;
            o_cnt        <= '0;
        end else begin
            hold_vld_reg <= 1'b0;
            if (i_clear) begin
                sum_ac_reg <= '0;
                sum_d_reg  <= '0;
                o_cnt      <= '0;
            end else if (a_vld_reg) begin
                if (o_cnt == LAST) begin
                    hold_ac_reg  <= sum_ac_next;
                    hold_d_reg   <= sum_d_next;
                    hold_ref_reg <= ph_ref_reg;
                    hold_vld_reg <= 1'b1;
                    sum_ac_reg   <= '0;
                    sum_d_reg    <= '0;
                    o_cnt        <= '0;
                end else begin
                    sum_ac_reg <= sum_ac_next;
                    sum_d_reg  <= sum_d_next;
                    o_cnt      <= o_cnt + 1'b1;
                end
            end
        end
    end

    // Stage C: divide by N, then re-centre the mean offset on the reference phase
    logic                    c_vld_reg;
    logic [31:0]             c_ac_reg;
    logic signed [33:0]      c_mean_reg;
    logic signed [33:0]      c_ref_reg;
    logic signed [D_W-1:0]   rnd_d;

    assign rnd_d = D_W'(RND);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_vld_reg  <= 1'b0;
            c_ac_reg   <= '0;
            c_mean_reg <= '0;
            c_ref_reg  <= '0;
            o_vld      <= 1'b0;
            o_ac       <= '0;
            o_ph       <= '0;
        end else begin
            c_vld_reg <= hold_vld_reg;
            if (hold_vld_reg) begin
                c_ac_reg   <= 32'(({1'b0, hold_ac_reg} + (AC_W + 1)'(RND)) >> LOG2_N);
                c_mean_reg <= 34'((hold_d_reg + rnd_d) >>> LOG2_N);
                c_ref_reg  <= hold_ref_reg;
            end
            o_vld <= c_vld_reg;
            if (c_vld_reg) begin
                o_ac <= c_ac_reg;
                o_ph <= 32'(wrap(c_ref_reg + c_mean_reg));
            end
        end
    end

endmodule

// File: tb/tb_ac_ph_avg.sv
// Directed bench for ac_ph_avg with a block-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_ac_ph_avg;

    localparam int     LOG2_N = 2;
    localparam int     N      = 1 << LOG2_N;
    localparam int     PH_PI  = 1073741824;
    localparam longint PI     = 1073741824;
`ifdef AC_PH_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                clk;
    logic                rstn;
    logic                i_vld;
    logic [31:0]         ac;
    logic signed [31:0]  ph;
    logic                i_clear;
    logic [31:0]         o_ac;
    logic signed [31:0]  o_ph;
    logic                o_vld;
    logic [LOG2_N:0]     o_cnt;

    ac_ph_avg #(.LOG2_N(LOG2_N), .PH_PI(PH_PI)) dut (
        .clk(clk), .rstn(rstn), .i_vld(i_vld), .ac(ac), .ph(ph), .i_clear(i_clear),
        .o_ac(o_ac), .o_ph(o_ph), .o_vld(o_vld), .o_cnt(o_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrapf(input longint x);
        if (x > PI) return x - 2 * PI;
        if (x <= -PI) return x + 2 * PI;
        return x;
    endfunction

    // Reference model: block bookkeeping straight from the averaging rules
    typedef struct {
        int     due;
        int     born;
        longint eac;
        longint eph;
    } res_t;
    res_t   pend_q[$];
    longint blk_ac = 0, blk_d = 0, blk_ref = 0;
    int     blk_n = 0;
    int     exp_ocnt = 0;
    longint exp_ac = 0, exp_ph = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                blk_ac = 0; blk_d = 0; blk_ref = 0; blk_n = 0;
                exp_ocnt = 0; exp_ac = 0; exp_ph = 0;
                pend_q.delete();
            end else begin
                exp_ocnt = i_clear ? 0 : blk_n;
                if (i_clear) begin
                    blk_ac = 0; blk_d = 0; blk_n = 0;
                    for (int i = pend_q.size() - 1; i >= 0; i--)
                        if (pend_q[i].born == cyc - 1) pend_q.delete(i);
                end
                if (i_vld) begin
                    longint wph, d, rnd, mean;
                    res_t r;
                    wph = wrapf(longint'(ph));
                    if (blk_n == 0) begin
                        blk_ref = wph;
                        d = 0;
                    end else begin
                        d = wrapf(wph - blk_ref);
                    end
                    blk_ac += longint'(ac);
                    blk_d  += d;
                    blk_n++;
                    if (blk_n == N) begin
                        rnd   = ROUND ? longint'(N / 2) : 0;
                        mean  = (blk_d + rnd) >>> LOG2_N;
                        r.due = cyc + 3;
                        r.born = cyc;
                        r.eac = (blk_ac + rnd) >> LOG2_N;
                        r.eph = wrapf(blk_ref + mean);
                        pend_q.push_back(r);
                        blk_ac = 0; blk_d = 0; blk_n = 0;
                    end
                end
            end
        end
    end

    // Compare process
    int     vld_cnt = 0;
    int     last_vld_cyc = 0;
    longint last_ac = 0, last_ph = 0;
    int     vld_cyc_q[$];
    longint vld_ac_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_o_vld", o_vld, 0);
                chk("rst_o_ac", o_ac, 0);
                chk("rst_o_ph", o_ph, 0);
                chk("rst_o_cnt", o_cnt, 0);
            end else begin
                bit exp_vld;
                exp_vld = 1'b0;
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    exp_vld = 1'b1;
                    exp_ac  = pend_q[0].eac;
                    exp_ph  = pend_q[0].eph;
                    void'(pend_q.pop_front());
                end
                chk("o_vld", o_vld, exp_vld);
                chk("o_ac", o_ac, exp_ac);
                chk("o_ph", o_ph, exp_ph);
                chk("o_cnt", o_cnt, exp_ocnt);
                if (o_vld) begin
                    vld_cnt++;
                    last_vld_cyc = cyc;
                    last_ac = o_ac;
                    last_ph = o_ph;
                    vld_cyc_q.push_back(cyc);
                    vld_ac_q.push_back(o_ac);
                    $display("out cyc=%0d o_ac=%0d o_ph=%0d", cyc, o_ac, o_ph);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] a, input logic signed [31:0] p, input logic c);
        i_vld = v; ac = a; ph = p; i_clear = c;
        @(posedge clk);
        #2;
        i_vld = 1'b0; i_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'sd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s4, qb;
        rstn = 1'b0; i_vld = 1'b0; i_clear = 1'b0; ac = '0; ph = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("init_o_ac", o_ac, 0);
        chk("init_o_cnt", o_cnt, 0);
        rstn = 1'b1;
        idle(2);

        // Amplitude mean and latency
        base = vld_cnt;
        step(1, 100, 0, 0); step(1, 200, 0, 0); step(1, 300, 0, 0); step(1, 400, 0, 0);
        s4 = cyc;
        idle(5);
        chk("amp_vld_count", vld_cnt - base, 1);
        chk("amp_o_ac", last_ac, 250);
        chk("amp_o_ph", last_ph, 0);
        chk("amp_latency", last_vld_cyc - s4, 3);

        // Phase wrap around +/-pi
        base = vld_cnt;
        step(1, 0, 32'sd1073741814, 0); step(1, 0, -32'sd1073741814, 0);
        step(1, 0, 32'sd1073741814, 0); step(1, 0, -32'sd1073741814, 0);
        idle(5);
        chk("wrap_vld_count", vld_cnt - base, 1);
        chk("wrap_o_ph", last_ph, 1073741824);

        // Rounding
        step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 2, 0, 0); step(1, 2, -32'sd1, 0);
        idle(5);
        chk("round_o_ac", last_ac, ROUND ? 2 : 1);
        chk("round_o_ph", last_ph, ROUND ? 0 : -1);

        // Clear discards a partial block
        base = vld_cnt;
        step(1, 1000, 0, 0); step(1, 1000, 0, 0);
        idle(1);
        chk("clr_cnt_before", o_cnt, 2);
        step(0, 0, 0, 1);
        chk("clr_cnt_after", o_cnt, 0);
        step(1, 8, 0, 0); step(1, 8, 0, 0); step(1, 8, 0, 0); step(1, 8, 0, 0);
        idle(5);
        chk("clr_vld_count", vld_cnt - base, 1);
        chk("clr_o_ac", last_ac, 8);

        // Clear coincident with a sample: that sample opens the new block
        base = vld_cnt;
        step(1, 100, 32'sd5000, 0);
        step(1, 5, 32'sd2000000000, 1);
        step(1, 5, -32'sd2000000000, 0);
        step(1, 5, 32'sd0, 0);
        step(1, 9, 32'sd100, 0);
        idle(5);
        chk("clrvld_vld_count", vld_cnt - base, 1);
        chk("clrvld_o_ac", last_ac, 6);
        chk("clrvld_o_ph", last_ph, 25);

        // Reset mid-block
        step(1, 40, 0, 0); step(1, 40, 0, 0); step(1, 40, 0, 0);
        idle(1);
        chk("rstmid_cnt_before", o_cnt, 3);
        chk("rstmid_ac_before", o_ac, 6);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rstmid_o_ac", o_ac, 0);
        chk("rstmid_o_ph", o_ph, 0);
        chk("rstmid_o_vld", o_vld, 0);
        chk("rstmid_o_cnt", o_cnt, 0);
        rstn = 1'b1;
        base = vld_cnt;
        step(1, 40, 0, 0); step(1, 40, 0, 0); step(1, 40, 0, 0); step(1, 40, 0, 0);
        idle(5);
        chk("rstmid_vld_count", vld_cnt - base, 1);
        chk("rstmid_o_ac_after", last_ac, 40);

        // Back-to-back blocks
        qb = vld_cyc_q.size();
        for (int i = 0; i < 4; i++) step(1, 10, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 20, 0, 0);
        idle(6);
        chk("b2b_vld_count", vld_cyc_q.size() - qb, 2);
        if (vld_cyc_q.size() - qb == 2) begin
            chk("b2b_spacing", vld_cyc_q[qb + 1] - vld_cyc_q[qb], 4);
            chk("b2b_first_ac", vld_ac_q[qb], 10);
            chk("b2b_second_ac", vld_ac_q[qb + 1], 20);
        end

        // Gapped block with edge-of-range phases, checked by the model only
        step(1, 7, -32'sd1073741823, 0);
        idle(2);
        step(1, 9, 32'sd1073741824, 0);
        idle(1);
        step(1, 3, -32'sd5, 0);
        step(1, 1, 32'sd1500000000, 0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
